sm_regdump: RTL and testbench

- Debug-port reader for the CPU's debug register access (regAddr out to CPU, regData in from CPU).
- On a start pulse, walks a register index range, samples each value, and streams {addr, data} beats on a valid/ready output.
- Feeds a host link or trace buffer.
- Index 0 on the debug port returns PC, not r0. Beat for index 0 therefore carries PC.

---
 rtl/sm_regdump_pkg.sv | 9 +
 rtl/sm_regdump.sv | 102 ++++++++++
 tb/tb_sm_regdump.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm_regdump_pkg.sv
// sm_regdump_pkg: shared encodings for the debug register dump engine.
package sm_regdump_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;
    // Debug index 0 reads back the PC rather than r0.
    localparam int PC_INDEX = 0;
endpackage

// File: rtl/sm_regdump.sv
// sm_regdump: walks a debug register index range and streams {addr, data} beats.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] range_lo,
    input  logic [AW-1:0] range_hi,
    input  logic          abort,
    output logic [AW-1:0] regAddr,
    input  logic [DW-1:0] regData,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          aborted
);
    logic [1:0]    state;
    logic [AW-1:0] cur;
    logic [AW-1:0] hiIdx;
    logic          errFlag;
    logic          abortPend;
    logic          xfer;

    assign xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur       <= '0;
            hiIdx     <= '0;
            errFlag   <= 1'b0;
            abortPend <= 1'b0;
            regAddr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    busy    <= 1'b1;
                    cur     <= range_lo;
                    hiIdx   <= range_hi;
                    errFlag <= range_lo > range_hi;
                    regAddr <= (range_lo > range_hi) ? regAddr : range_lo;
                    state   <= (range_lo > range_hi) ? ST_FIN : ST_ADDR;
                end
                ST_ADDR: if (abort) begin
                    abortPend <= 1'b1;
                    state     <= ST_FIN;
                end else begin
                    out_data  <= regData;
                    out_addr  <= cur;
                    out_last  <= cur == hiIdx;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (abort)
                        abortPend <= 1'b1;
                    // The last-beat check precedes the increment, so cur never passes hiIdx.
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (out_last || abortPend || abort) begin
                            abortPend <= abortPend | abort;
                            state     <= ST_FIN;
                        end else begin
                            cur     <= cur + AW'(1);
                            regAddr <= cur + AW'(1);
                            state   <= ST_ADDR;
                        end
                    end
                end
                default: begin
                    done      <= ~abortPend;
                    err       <= errFlag & ~abortPend;
                    aborted   <= abortPend;
                    abortPend <= 1'b0;
                    errFlag   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: directed bench with a beat-list model of the register dump engine.
module tb_sm_regdump;
    import sm_regdump_pkg::*;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  range_lo = '0;
    logic [4:0]  range_hi = '0;
    logic        abort = 1'b0;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;

    logic [31:0] regs [32];
    logic [31:0] pc;
    beat_t       expQ [$];
    logic [2:0]  expPulse;
    int checks = 0, failures = 0;
    int cyc = 0, startEdge = 0, pulseEdge = 0, firstValidEdge = -1;
    int beatsSeen = 0, pulses = 0;
    logic [31:0] seen5 = '0;
    logic        prevValid = 1'b0, prevReady = 1'b0;
    logic [4:0]  prevAddr = '0;
    logic [31:0] prevData = '0;

    sm_regdump dut (
        .clk(clk), .rst(rst), .start(start), .range_lo(range_lo), .range_hi(range_hi),
        .abort(abort), .regAddr(regAddr), .regData(regData), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err), .aborted(aborted)
    );

    // CPU debug port: combinational read, index 0 aliases the PC.
    assign regData = (regAddr == 5'(PC_INDEX)) ? pc : regs[regAddr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] cpuVal(input int i);
        return (i == PC_INDEX) ? pc : regs[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t mb;
        if (!rst) begin
            if (prevValid && !prevReady) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_addr", 32'(out_addr), 32'(prevAddr));
                chk("hold_data", out_data, prevData);
            end
            if (out_valid && firstValidEdge < 0)
                firstValidEdge = cyc;
            if (out_valid && out_ready) begin
                beatsSeen++;
                if (out_addr == 5'd5)
                    seen5 = out_data;
                chk("beat_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    mb = expQ.pop_front();
                    chk("beat_addr", 32'(out_addr), 32'(mb.a));
                    chk("beat_data", out_data, mb.d);
                    chk("beat_last", 32'(out_last), 32'(mb.l));
                end
            end
            if (done || err || aborted) begin
                pulses++;
                pulseEdge = cyc;
                chk("end_pulse", 32'({done, err, aborted}), 32'(expPulse));
                chk("beats_left", expQ.size(), 32'd0);
            end
        end
        prevValid = out_valid;
        prevReady = out_ready;
        prevAddr  = out_addr;
        prevData  = out_data;
    end

    task automatic doStart(input int lo, input int hi);
        @(posedge clk);
        #1 start = 1'b1;
        range_lo = 5'(lo);
        range_hi = 5'(hi);
        @(posedge clk);
        #1 start = 1'b0;
        startEdge = cyc;
    endtask

    task automatic setup(input int lo, input int hi, input logic [2:0] pulse);
        expQ.delete();
        for (int i = lo; i <= hi; i++)
            expQ.push_back('{a: 5'(i), d: cpuVal(i), l: (i == hi)});
        expPulse = pulse;
        beatsSeen = 0;
        pulses = 0;
        firstValidEdge = -1;
    endtask

    task automatic finishDump(input string name, input int expBeats);
        int n = 0;
        while (pulses == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_pulses"}, pulses, 32'd1);
        chk({name, "_beats"}, beatsSeen, 32'(expBeats));
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = 32'hA000_0000 + 32'(i);
        regs[5] = 32'h1234;
        pc = 32'h10;
        expPulse = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regAddr", 32'(regAddr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({done, err, aborted}), 32'd0);
        rst = 1'b0;

        // Full dump with the PC aliasing index 0.
        setup(0, 31, 3'b100);
        chk("model_pc", expQ[0].d, 32'h10);
        chk("model_r5", expQ[5].d, 32'h1234);
        chk("model_last", 32'(expQ[31].l), 32'd1);
        doStart(0, 31);
        finishDump("full", 32);
        chk("full_latency", pulseEdge - startEdge, 32'd65);
        chk("full_first_valid", firstValidEdge - startEdge, 32'd1);
        chk("full_r5_seen", seen5, 32'h1234);

        // Backpressure on the first beat.
        out_ready = 1'b0;
        setup(3, 4, 3'b100);
        doStart(3, 4);
        chk("bp_regAddr", 32'(regAddr), 32'd3);
        chk("bp_busy", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_held_addr", 32'(out_addr), 32'd3);
        chk("bp_held_data", out_data, 32'hA000_0003);
        out_ready = 1'b1;
        finishDump("bp", 2);

        // Single-index and inverted ranges.
        setup(7, 7, 3'b100);
        doStart(7, 7);
        finishDump("single", 1);
        setup(9, 2, 3'b110);
        doStart(9, 2);
        finishDump("invalid", 0);
        chk("invalid_latency", pulseEdge - startEdge, 32'd1);

        // Abort while beat 2 is stalled in SEND.
        out_ready = 1'b0;
        setup(2, 2, 3'b001);
        expQ[0].l = 1'b0;
        doStart(2, 5);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        finishDump("abort_send", 1);

        // Abort while index 11 is being addressed.
        setup(10, 10, 3'b001);
        expQ[0].l = 1'b0;
        doStart(10, 12);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        finishDump("abort_addr", 1);

        // A second start during a dump is ignored.
        setup(0, 3, 3'b100);
        doStart(0, 3);
        @(posedge clk);
        #1 start = 1'b1;
        range_lo = 5'd20;
        range_hi = 5'd25;
        @(posedge clk);
        #1 start = 1'b0;
        finishDump("busy_start", 4);

        // Reset mid-dump, then a dump ending at the top index.
        setup(0, 31, 3'b100);
        doStart(0, 31);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_pulse", pulses, 32'd0);
        setup(28, 31, 3'b100);
        doStart(28, 31);
        finishDump("top", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
